// File: rtl/bus_switch_arbiter_if.sv
// rtl/bus_switch_arbiter_if.sv - request/grant/select bundle between requesters and the line-switch arbiter
// The master side is the pair of requesters; the slave side is the arbiter.
interface bus_switch_arbiter_if;
  logic req1;
  logic req2;
  logic gnt1;
  logic gnt2;
  logic sel;
  logic busy;
  logic timeout;

  modport master (
    output req1,
    output req2,
    input  gnt1,
    input  gnt2,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req1,
    input  req2,
    output gnt1,
    output gnt2,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_switch_arbiter.sv
// rtl/bus_switch_arbiter.sv - round-robin owner of the a<->b1/b2 line switch
// Drives the switch select and grants, with settle/guard intervals and optional hold-limit pre-emption.
module bus_switch_arbiter #(
  parameter int SETTLE   = 4,
  parameter int GUARD    = 2,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_switch_arbiter_if.slave  bus
);

  localparam int MAX_SG = (SETTLE > GUARD) ? SETTLE : GUARD;
  localparam int MAX_P  = (MAX_SG > MAX_HOLD) ? MAX_SG : MAX_HOLD;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] GUARD_END  = CW'(GUARD - 1);
  localparam logic [CW-1:0] HOLD_LIM   = CW'(MAX_HOLD);
  // Saturating at the limit keeps the equality test live for a late-arriving competitor.
  localparam logic [CW-1:0] HOLD_SAT   = (MAX_HOLD == 0) ? {CW{1'b1}} : CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  // Requester encoding for win/last: 0 = requester 1, 1 = requester 2.
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          gnt1_q, gnt1_d;
  logic          gnt2_q, gnt2_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          req_own;
  logic          req_other;
  logic          win_idle;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    win_d     = win_q;
    last_d    = last_q;
    sel_d     = sel_q;
    gnt1_d    = gnt1_q;
    gnt2_d    = gnt2_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    req_own   = win_q ? bus.req2 : bus.req1;
    req_other = win_q ? bus.req1 : bus.req2;
    win_idle  = (bus.req1 && bus.req2) ? ~last_q : bus.req2;

    case (state_q)
      S_IDLE: begin
        if (bus.req1 || bus.req2) begin
          win_d  = win_idle;
          busy_d = 1'b1;
          if (sel_q == ~win_idle) begin
            state_d = S_GRANT;
            gnt1_d  = ~win_idle;
            gnt2_d  = win_idle;
            last_d  = win_idle;
            hold_d  = CNT_ONE;
          end else begin
            state_d = S_SETTLE;
            sel_d   = ~win_idle;
            cnt_d   = '0;
          end
        end
      end

      S_SETTLE: begin
        if (!req_own) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == SETTLE_END) begin
          state_d = S_GRANT;
          gnt1_d  = ~win_q;
          gnt2_d  = win_q;
          last_d  = win_q;
          hold_d  = CNT_ONE;
        end else begin
          cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
        end
      end

      S_GRANT: begin
        if (!req_own) begin
          state_d = S_RELEASE;
          gnt1_d  = 1'b0;
          gnt2_d  = 1'b0;
          cnt_d   = '0;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LIM) && req_other) begin
          state_d   = S_RELEASE;
          gnt1_d    = 1'b0;
          gnt2_d    = 1'b0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + CNT_ONE;
        end
      end

      S_RELEASE: begin
        if (cnt_q == GUARD_END) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt1_d  = 1'b0;
        gnt2_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      sel_q     <= 1'b1;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      win_q     <= win_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      gnt1_q    <= gnt1_d;
      gnt2_q    <= gnt2_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt1    = gnt1_q;
  assign bus.gnt2    = gnt2_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
